// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

    // ARB: CPU/DMA arbitration; CLEAR: zero-fill sequencer owns the memory
    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Requester IDs; also the bit positions in the one-hot grant vector
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int DEF_DEPTH_WORDS = 8192;

    localparam logic [3:0] BYTEEN_FULL = 4'hF;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with one-hot grant
//
// Ports:
//   req[1:0]  requests, bit 0 = CPU, bit 1 = DMA
//   last      ID of the most recently granted requester
//   enable    when low no grant is given
//   gnt[1:0]  one-hot grant, same bit order as req
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: the side that did not win last time goes now
                2'b11:   gnt = (last == REQ_DMA) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/DMA data-memory arbiter with zero-fill sequencer
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cpu_* / dma_*                 requester bundles (req, we, addr, wdata, byteen)
//   cpu_stall, cpu_rdata          CPU access not performed / read data
//   dma_gnt, dma_rdata            DMA access performed / read data
//   clr_start, clr_busy, clr_done zero-fill control and status
//   dm_we/addr/wdata/byteen       drive the data memory
//   dm_rdata                      combinational read data from the memory
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int CNT_W       = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_byteen,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        clr_done,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;
    logic               r_clr_done;
    logic [1:0]         w_gnt;
    logic               w_arb_en;
    logic               w_cnt_last;

    // Reset gates the grant so the memory sees no traffic while rst is low
    assign w_arb_en   = (r_state == ARB) && rst;
    assign w_cnt_last = (r_cnt == CNT_W'(DEPTH_WORDS - 1));

    rr_arb2 u_rr_arb2 (
        .req    ({dma_req, cpu_req}),
        .last   (r_last),
        .enable (w_arb_en),
        .gnt    (w_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        dm_we       = 1'b0;
        dm_addr     = 32'h0;
        dm_wdata    = 32'h0;
        dm_byteen   = 4'h0;
        case (r_state)
            ARB: begin
                if (w_gnt[REQ_CPU]) begin
                    dm_we     = cpu_we;
                    dm_addr   = cpu_addr;
                    dm_wdata  = cpu_wdata;
                    dm_byteen = cpu_byteen;
                end else if (w_gnt[REQ_DMA]) begin
                    dm_we     = dma_we;
                    dm_addr   = dma_addr;
                    dm_wdata  = dma_wdata;
                    dm_byteen = dma_byteen;
                end
                if (clr_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                dm_we     = 1'b1;
                dm_byteen = BYTEEN_FULL;
                dm_addr   = {{(30 - CNT_W){1'b0}}, r_cnt, 2'b00};
                // Exit on the last word rather than relying on overflow
                if (w_cnt_last) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ARB;
            r_cnt      <= '0;
            r_last     <= REQ_DMA;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_done <= (r_state == CLEAR) && w_cnt_last;
            if (r_state == ARB) begin
                if (clr_start) begin
                    r_cnt <= '0;
                end
                if (|w_gnt) begin
                    r_last <= w_gnt[REQ_DMA];
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign cpu_stall = cpu_req & ~w_gnt[REQ_CPU];
    assign dma_gnt   = w_gnt[REQ_DMA];
    assign cpu_rdata = dm_rdata;
    assign dma_rdata = dm_rdata;
    assign clr_busy  = (r_state == CLEAR);
    assign clr_done  = r_clr_done;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard testbench for dm_arbiter
module tb_dm_arbiter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, clr_start;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [3:0]  cpu_byteen, dma_byteen;
    logic        cpu_stall, dma_gnt, clr_busy, clr_done, dm_we;
    logic [31:0] cpu_rdata, dma_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_byteen;

    always #5 clk = ~clk;

    dm_arbiter #(.DEPTH_WORDS(DEPTH), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_byteen(dma_byteen),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_byteen(dm_byteen), .dm_rdata(dm_rdata)
    );

    // Data memory: combinational read, byte-enabled write at the edge
    logic [31:0] tb_mem [DEPTH];
    assign dm_rdata = tb_mem[dm_addr[5:2]];
    always @(posedge clk) begin
        if (dm_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_byteen[b]) tb_mem[dm_addr[5:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        stall, gnt, we, busy, done;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        bit          chk_c, chk_d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;

    // Reference model: memory image, clear progress, who won last
    logic [31:0] ref_mem [DEPTH];
    bit m_clr;
    int m_idx;
    bit m_last;
    bit m_done;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("cpu_stall", 32'(cpu_stall), 32'(mon_e.stall));
            chk("dma_gnt",   32'(dma_gnt),   32'(mon_e.gnt));
            chk("dm_we",     32'(dm_we),     32'(mon_e.we));
            chk("dm_addr",   dm_addr,        mon_e.addr);
            chk("dm_wdata",  dm_wdata,       mon_e.wdata);
            chk("dm_byteen", 32'(dm_byteen), 32'(mon_e.be));
            chk("clr_busy",  32'(clr_busy),  32'(mon_e.busy));
            chk("clr_done",  32'(clr_done),  32'(mon_e.done));
            if (mon_e.chk_c) chk("cpu_rdata", cpu_rdata, mon_e.rdata);
            if (mon_e.chk_d) chk("dma_rdata", dma_rdata, mon_e.rdata);
        end
    end

    task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic [3:0] cb, input bit dr, input bit dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic [3:0] db, input bit cs);
        exp_t e;
        bit win_c, win_d;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; cpu_byteen = cb;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_byteen = db;
        clr_start = cs;
        e.stall = 1'b0; e.gnt = 1'b0; e.we = 1'b0; e.addr = 32'h0; e.wdata = 32'h0;
        e.be = 4'h0; e.rdata = 32'h0; e.chk_c = 1'b0; e.chk_d = 1'b0;
        e.busy = m_clr; e.done = m_done;
        win_c = 1'b0; win_d = 1'b0;
        if (m_clr) begin
            e.we = 1'b1; e.be = 4'hF; e.addr = 32'(m_idx * 4); e.stall = cr;
        end else begin
            // Uncontested requests win; on a collision the one not served last wins
            win_c = cr && (!dr || m_last);
            win_d = dr && !win_c;
            e.stall = cr && !win_c;
            e.gnt = win_d;
            if (win_c) begin
                e.we = cw; e.addr = ca; e.wdata = cd; e.be = cb;
                e.chk_c = !cw; e.rdata = ref_mem[ca[5:2]];
            end else if (win_d) begin
                e.we = dw; e.addr = da; e.wdata = dd; e.be = db;
                e.chk_d = !dw; e.rdata = ref_mem[da[5:2]];
            end
        end
        q.push_back(e);
        if (m_clr) begin
            ref_mem[m_idx] = 32'h0;
            m_done = (m_idx == DEPTH - 1);
            if (m_done) m_clr = 1'b0;
            else m_idx++;
        end else begin
            m_done = 1'b0;
            if (e.we) begin
                for (int b = 0; b < 4; b++) begin
                    if (e.be[b]) ref_mem[e.addr[5:2]][8*b +: 8] = e.wdata[8*b +: 8];
                end
            end
            if (win_c) m_last = 1'b0;
            else if (win_d) m_last = 1'b1;
            if (cs) begin
                m_clr = 1'b1;
                m_idx = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_byteen = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_byteen = 0;
        clr_start = 0;
        rst = 1'b0;
        #1;
        chk("rst_dm_we",     32'(dm_we),     32'h0);
        chk("rst_dm_addr",   dm_addr,        32'h0);
        chk("rst_dm_wdata",  dm_wdata,       32'h0);
        chk("rst_dm_byteen", 32'(dm_byteen), 32'h0);
        chk("rst_clr_busy",  32'(clr_busy),  32'h0);
        chk("rst_clr_done",  32'(clr_done),  32'h0);
        @(posedge clk); #1;
        chk("rst_no_done",   32'(clr_done),  32'h0);
        @(posedge clk); #1;
        m_clr = 1'b0; m_idx = 0; m_done = 1'b0; m_last = 1'b1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] raddr();
        return {26'h0, 4'($urandom_range(0, DEPTH - 1)), 2'b00};
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        @(posedge clk); #1;
        do_reset();

        // Full clear, with requests and clr_start re-asserted while busy
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++)
            drive($urandom_range(0, 1), $urandom_range(0, 1), raddr(), $urandom, 4'hF,
                  $urandom_range(0, 1), 1, raddr(), $urandom, 4'hF, $urandom_range(0, 1));
        idle();
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 32'(i * 4), 0, 4'hF, 0, 0, 0, 0, 0, 0);

        // CPU word store then readback
        drive(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0);

        // Contention right after reset: CPU first, then alternation
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1, 0, 32'h10, 0, 4'hF, 1, 0, 32'h10, 0, 4'hF, 0);

        // DMA byte store wins a collision; CPU byteen must not leak
        drive(1, 1, 32'h14, 32'h11223344, 4'hF, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h14, 32'hFFFFFFFF, 4'h3, 1, 1, 32'h14, 32'h00AB0000, 4'b0100, 0);
        drive(1, 0, 32'h14, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        chk("sb_word", tb_mem[5], 32'h11AB3344);

        // Random traffic with occasional clears
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 1), $urandom_range(0, 1), raddr(), $urandom, 4'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1), raddr(), $urandom, 4'($urandom),
                  ($urandom_range(0, 39) == 0));
        while (m_clr) idle();
        idle();

        // Reset while the clear is at word 7, then a fresh clear from word 0
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) idle();
        do_reset();
        for (int i = 0; i < 7; i++) chk("abort_zero", tb_mem[i], 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH + 1; i++) drive(1, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        idle();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
